regfile_write_arbiter: RTL

Shares the register file's single write port (regwrite, wreg, wdata) between two writeback requesters: port 0 carries ALU results and port 1 carries load results. Each port has a 2-entry FIFO and a valid/ready handshake. A round-robin arbiter drains one entry per cycle into registered write-port outputs. A combinational pending-lookup lets the decode/stall logic detect reads of registers that still have queued writes.

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between the ALU and load writeback
// paths: two 2-entry FIFOs, a round-robin drain and a pending-write lookup.
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_reg,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_reg,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    input  logic [4:0]  qreg,
    output logic        pend_hit,
    output logic        regwrite,
    output logic [4:0]  wreg,
    output logic [31:0] wdata
);
    localparam int DEPTH = 2;

    logic [4:0]  ent_reg_q  [2][DEPTH];
    logic [31:0] ent_data_q [2][DEPTH];
    logic [1:0]  cnt_q [2];
    logic [1:0]  cnt_d [2];
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic        prio_q, prio_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic [1:0]  vld, rdy, push, pop, nempty;
    logic        gnt, gnt_vld;
    logic [4:0]  head_reg;
    logic [31:0] head_data;
    logic [4:0]  in_reg  [2];
    logic [31:0] in_data [2];

    assign vld        = {wb1_valid, wb0_valid};
    assign in_reg[0]  = wb0_reg;
    assign in_reg[1]  = wb1_reg;
    assign in_data[0] = wb0_data;
    assign in_data[1] = wb1_data;

    assign rdy[0]    = cnt_q[0] != 2'd2;
    assign rdy[1]    = cnt_q[1] != 2'd2;
    assign nempty[0] = cnt_q[0] != 2'd0;
    assign nempty[1] = cnt_q[1] != 2'd0;
    assign push      = vld & rdy;

    // Lone candidate wins outright; a tie goes to the port named by prio.
    assign gnt_vld   = |nempty;
    assign gnt       = (&nempty) ? prio_q : nempty[1];
    assign pop[0]    = gnt_vld && !gnt;
    assign pop[1]    = gnt_vld && gnt;
    assign head_reg  = ent_reg_q[gnt][head_q[gnt]];
    assign head_data = ent_data_q[gnt][head_q[gnt]];

    assign wb0_ready = rdy[0];
    assign wb1_ready = rdy[1];
    assign regwrite  = regwrite_q;
    assign wreg      = wreg_q;
    assign wdata     = wdata_q;

    // Pending lookup over occupied FIFO slots and the live output stage.
    always_comb begin
        logic hit;
        hit = regwrite_q && (wreg_q == qreg);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((cnt_q[k] == 2'd2 ||
                     (cnt_q[k] == 2'd1 && head_q[k] == 1'(i))) &&
                    ent_reg_q[k][i] == qreg)
                    hit = 1'b1;
            end
        end
        pend_hit = hit && (qreg != 5'd0);
    end

    // Next state for pointers, counts, arbiter priority and write port.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        prio_d     = prio_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        for (int k = 0; k < 2; k++)
            cnt_d[k] = cnt_q[k];
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            prio_d  = 1'b0;
            wreg_d  = '0;
            wdata_d = '0;
            for (int k = 0; k < 2; k++)
                cnt_d[k] = 2'd0;
        end else begin
            head_d = head_q ^ pop;
            tail_d = tail_q ^ push;
            for (int k = 0; k < 2; k++)
                cnt_d[k] = cnt_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
            if (gnt_vld) begin
                prio_d     = ~gnt;
                regwrite_d = head_reg != 5'd0;
                wreg_d     = head_reg;
                wdata_d    = head_data;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            prio_q     <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            for (int k = 0; k < 2; k++)
                cnt_q[k] <= 2'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            prio_q     <= prio_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            for (int k = 0; k < 2; k++)
                cnt_q[k] <= cnt_d[k];
        end
    end

    // FIFO storage; entries accepted during a flush are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_reg_q[k][i]  <= '0;
                    ent_data_q[k][i] <= '0;
                end
            end
        end else if (!flush) begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    ent_reg_q[k][tail_q[k]]  <= in_reg[k];
                    ent_data_q[k][tail_q[k]] <= in_data[k];
                end
            end
        end
    end
endmodule
